// File: rtl/cardinal_pkg.sv
// cardinal_pkg
// Shared constants and types for the cardinal ALU family.
//   - Opcode encodings for the vector divide / modulo / square-root unit
//   - Lane-width (ww) encodings
//   - State type for the iterative divide FSM
//   - lane_width(): maps a ww encoding to its lane width in bits
package cardinal_pkg;

    localparam logic [5:0] VDIVU  = 6'd14;
    localparam logic [5:0] VMODU  = 6'd15;
    localparam logic [5:0] VSQRTU = 6'd18;

    typedef enum logic [1:0] {
        WW_BYTE   = 2'b00,
        WW_HALF   = 2'b01,
        WW_WORD   = 2'b10,
        WW_DOUBLE = 2'b11
    } ww_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } vdiv_state_e;

    function automatic logic [6:0] lane_width(input logic [1:0] ww);
        case (ww_e'(ww))
            WW_BYTE:  lane_width = 7'd8;
            WW_HALF:  lane_width = 7'd16;
            WW_WORD:  lane_width = 7'd32;
            default:  lane_width = 7'd64;
        endcase
    endfunction

endpackage

// File: rtl/vdiv_step.sv
// vdiv_step
// Combinational single iteration of the restoring divide / square-root
// datapath, applied to every lane of a DATA_W-bit vector in parallel.
// Lane boundaries follow ww; no carry or borrow crosses a lane edge.
// Ports:
//   ww        lane width select (8/16/32/64 bits)
//   sqrt_mode 1 = square-root iteration, 0 = divide iteration
//   rem       partial remainder per lane
//   quo       divide: dividend shifting out / quotient shifting in
//             sqrt:   radicand shifting out two bits per step
//   div       divide: divisor (unchanged); sqrt: partial root
//   rem_next, quo_next, div_next   values after one iteration
module vdiv_step
    import cardinal_pkg::*;
#(
    parameter int DATA_W = 64
) (
    input  logic [1:0]        ww,
    input  logic              sqrt_mode,
    input  logic [DATA_W-1:0] rem,
    input  logic [DATA_W-1:0] quo,
    input  logic [DATA_W-1:0] div,
    output logic [DATA_W-1:0] rem_next,
    output logic [DATA_W-1:0] quo_next,
    output logic [DATA_W-1:0] div_next
);

    logic [DATA_W-1:0] rem_opt [4];
    logic [DATA_W-1:0] quo_opt [4];
    logic [DATA_W-1:0] div_opt [4];

    // One full-width datapath per lane width; ww picks one afterwards.
    for (genvar g = 0; g < 4; g++) begin : g_width
        localparam int W = 8 << g;

        logic [DATA_W-1:0] r_n, q_n, d_n;
        logic [W-1:0]      r, q, d, sh, tr;
        logic              ge;

        always_comb begin
            r_n = '0;
            q_n = '0;
            d_n = '0;
            r   = '0;
            q   = '0;
            d   = '0;
            sh  = '0;
            tr  = '0;
            ge  = 1'b0;
            for (int l = 0; l < DATA_W / W; l++) begin
                r = rem[l*W +: W];
                q = quo[l*W +: W];
                d = div[l*W +: W];
                if (sqrt_mode) begin
                    // Bring down two radicand bits, trial subtract 4*root+1.
                    sh = {r[W-3:0], q[W-1:W-2]};
                    tr = {d[W-3:0], 2'b01};
                    ge = (sh >= tr);
                    r_n[l*W +: W] = ge ? (sh - tr) : sh;
                    q_n[l*W +: W] = {q[W-3:0], 2'b00};
                    d_n[l*W +: W] = {d[W-2:0], ge};
                end else begin
                    // The bit shifted out of the remainder is the (W+1)th bit
                    // of the trial value; if set, the divisor always fits.
                    sh = {r[W-2:0], q[W-1]};
                    tr = '0;
                    ge = r[W-1] | (sh >= d);
                    r_n[l*W +: W] = ge ? (sh - d) : sh;
                    q_n[l*W +: W] = {q[W-2:0], ge};
                    d_n[l*W +: W] = d;
                end
            end
        end

        assign rem_opt[g] = r_n;
        assign quo_opt[g] = q_n;
        assign div_opt[g] = d_n;
    end

    always_comb begin
        rem_next = rem_opt[3];
        quo_next = quo_opt[3];
        div_next = div_opt[3];
        case (ww_e'(ww))
            WW_BYTE: begin
                rem_next = rem_opt[0];
                quo_next = quo_opt[0];
                div_next = div_opt[0];
            end
            WW_HALF: begin
                rem_next = rem_opt[1];
                quo_next = quo_opt[1];
                div_next = div_opt[1];
            end
            WW_WORD: begin
                rem_next = rem_opt[2];
                quo_next = quo_opt[2];
                div_next = div_opt[2];
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/alu_vdiv.sv
// alu_vdiv
// Iterative vector unsigned divide (vdivu), modulo (vmodu) and integer
// square root (vsqrtu). One restoring iteration per cycle on all lanes.
// Ports:
//   clk, reset        clock and asynchronous active-high reset
//   start             request, sampled only in IDLE
//   opcode            14 vdivu, 15 vmodu, 18 vsqrtu (others illegal)
//   ww                lane width: 8/16/32/64 bits
//   op1, op2          dividend/radicand and divisor, bit 0 is MSB
//   busy              high whenever the FSM is not IDLE
//   done              one-cycle pulse, result valid
//   result            per-lane result, held until the next completion
module alu_vdiv
    import cardinal_pkg::*;
#(
    parameter int DATA_W  = 64,
    parameter int SQRT_EN = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [5:0]        opcode,
    input  logic [1:0]        ww,
    input  logic [0:DATA_W-1] op1,
    input  logic [0:DATA_W-1] op2,
    output logic              busy,
    output logic              done,
    output logic [0:DATA_W-1] result
);

    vdiv_state_e       state;
    logic [6:0]        count;
    logic [5:0]        opcode_r;
    logic [1:0]        ww_r;
    logic [DATA_W-1:0] rem_r, quo_r, div_r;
    logic [DATA_W-1:0] rem_n, quo_n, div_n;
    logic [DATA_W-1:0] final_value;
    logic              legal;
    logic [6:0]        width;
    logic [6:0]        start_count;

    assign legal = (opcode == VDIVU) || (opcode == VMODU) ||
                   ((SQRT_EN != 0) && (opcode == VSQRTU));

    // Square root retires two radicand bits per step, so needs half the steps.
    assign width       = lane_width(ww);
    assign start_count = (opcode == VSQRTU) ? {1'b0, width[6:1]} : width;

    assign busy = (state != IDLE);

    vdiv_step #(
        .DATA_W(DATA_W)
    ) u_step (
        .ww       (ww_r),
        .sqrt_mode(opcode_r == VSQRTU),
        .rem      (rem_r),
        .quo      (quo_r),
        .div      (div_r),
        .rem_next (rem_n),
        .quo_next (quo_n),
        .div_next (div_n)
    );

    // The last iteration's outputs feed the result directly, so result is
    // loaded on the same edge that enters DONE.
    always_comb begin
        final_value = quo_n;
        if (opcode_r == VMODU) begin
            final_value = rem_n;
        end else if (opcode_r == VSQRTU) begin
            final_value = div_n;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            count    <= '0;
            opcode_r <= '0;
            ww_r     <= '0;
            rem_r    <= '0;
            quo_r    <= '0;
            div_r    <= '0;
            done     <= 1'b0;
            result   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        if (legal) begin
                            state    <= RUN;
                            count    <= start_count;
                            opcode_r <= opcode;
                            ww_r     <= ww;
                            rem_r    <= '0;
                            quo_r    <= op1;
                            div_r    <= (opcode == VSQRTU) ? '0 : op2;
                        end else begin
                            state  <= DONE;
                            done   <= 1'b1;
                            result <= '0;
                        end
                    end
                end
                RUN: begin
                    rem_r <= rem_n;
                    quo_r <= quo_n;
                    div_r <= div_n;
                    count <= count - 7'd1;
                    if (count == 7'd1) begin
                        state  <= DONE;
                        done   <= 1'b1;
                        result <= final_value;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
